njesia_kontrollit: RTL and testbench
====================================

NJESIA_KONTROLLIT -- requirements
Module: njesia_kontrollit

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset: Clock input 1 (rising edge); Resetn input 1 (async, active-low).
REQ-002 SHALL have Opcode input 4, the instruction-register opcode field, stable after IRWrite.
REQ-003 SHALL have Funct input 2, the R-type function field.
REQ-004 SHALL have Zero input 1, the combinational ALU zero flag.
REQ-005 SHALL have MemReady input 1, the memory-done handshake.
REQ-006 SHALL have AluSel output 2: 00 AND, 01 OR, 10 ADD, 11 SUB; drives the ALU result mux select.
REQ-007 SHALL have AluSrcA output 1: 0 PC, 1 regA.
REQ-008 SHALL have AluSrcB output 2: 00 regB, 01 constant 1, 10 immediate.
REQ-009 SHALL have 1-bit outputs IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc (0 ALU, 1 branch target), RegWrite, RegDst, MemToReg, Halted and IllegalOp.
REQ-010 SHALL have Gjendja output 3, the current state for debug.

Function
REQ-011 SHALL be a multicycle FSM with states START 000, FETCH 001, DECODE 010, EXEC 011, MEM 100, WB 101, HALT 110.
REQ-012 SHALL drive every output 0 in any state or condition not listed below.
REQ-013 START: all outputs 0; next state FETCH.
REQ-014 FETCH: MemRead=1, IorD=0; hold FETCH while MemReady=0.
REQ-015 FETCH with MemReady=1 in the same cycle: IRWrite=1, PCWrite=1, AluSrcA=0, AluSrcB=01, AluSel=10 (PC+1); next state DECODE.
REQ-016 DECODE: no strobes; next state EXEC for legal opcodes 0000 R, 0100 ADDI, 1000 LW, 1100 SW, 0010 BEQ.
REQ-017 DECODE with opcode 1111: next state HALT.
REQ-018 DECODE with any other opcode: IllegalOp=1 for exactly this one cycle; next state FETCH.
REQ-019 EXEC, R: AluSrcA=1, AluSrcB=00, AluSel=Funct; next state WB.
REQ-020 EXEC, ADDI: AluSrcA=1, AluSrcB=10, AluSel=10; next state WB.
REQ-021 EXEC, LW or SW: AluSrcA=1, AluSrcB=10, AluSel=10; next state MEM.
REQ-022 EXEC, BEQ: AluSrcA=1, AluSrcB=00, AluSel=11, PCSrc=1, PCWrite=Zero (same cycle); next state FETCH.
REQ-023 MEM: IorD=1; MemRead=1 for LW, MemWrite=1 for SW; hold MEM while MemReady=0 with no limit.
REQ-024 MEM exit on MemReady=1: LW goes to WB, SW goes to FETCH.
REQ-025 WB: RegWrite=1; R sets RegDst=1, MemToReg=0; ADDI sets RegDst=0, MemToReg=0; LW sets RegDst=0, MemToReg=1; next state FETCH.
REQ-026 HALT: Halted=1 and all strobes 0; leave HALT only through reset.
REQ-027 Outputs SHALL be combinational from state, Opcode, Funct, Zero and MemReady (Moore/Mealy as listed); no registered outputs except Gjendja.
REQ-028 Instruction latency: R/ADDI 5 cycles, LW 6, SW 5, BEQ 4 (zero wait states).

Reset
REQ-029 Resetn=0 SHALL force the state to START asynchronously, so all outputs are 0 and Gjendja=000 without waiting for a Clock edge.
REQ-030 Reset in any state, including MEM mid-handshake, SHALL abort the instruction; the first edge after release moves START to FETCH.

Structure
REQ-031 Package ctrl_pkg SHALL hold state encodings, opcode constants, and the AluSel and AluSrcB encodings.
REQ-032 One sub-module alu_dekoder (combinational: state class plus Funct to AluSel) SHALL be used; everything else stays flat.

Verification
REQ-033 Reset release, MemReady=1 constant, Opcode=0000, Funct=01 -> states START, FETCH, DECODE, EXEC (AluSel=01), WB (RegWrite=1, RegDst=1), then FETCH.
REQ-034 LW with MemReady low for 3 MEM cycles -> MEM held 4 cycles with MemRead=1, IorD=1, then WB with MemToReg=1; total 9 cycles.
REQ-035 BEQ with Zero=1 -> PCWrite=1, PCSrc=1 in EXEC; with Zero=0 -> PCWrite=0; both return to FETCH.
REQ-036 Opcode=0111 -> IllegalOp single-cycle pulse in DECODE, next state FETCH; Opcode=1111 -> Halted=1 held 20 cycles regardless of inputs.
REQ-037 Resetn dropped mid-MEM on SW -> MemWrite=0 and Gjendja=000 before the next Clock edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU operation and ALU operand-B selects, plus the ALU decode classes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_START  = 3'b000,
    ST_FETCH  = 3'b001,
    ST_DECODE = 3'b010,
    ST_EXEC   = 3'b011,
    ST_MEM    = 3'b100,
    ST_WB     = 3'b101,
    ST_HALT   = 3'b110
  } state_e;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1100;
  localparam logic [3:0] OP_BEQ  = 4'b0010;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // What the ALU is being used for in the current cycle.
  typedef enum logic [2:0] {
    AC_NONE,
    AC_INC,
    AC_FUNCT,
    AC_ADD,
    AC_SUB
  } alu_class_e;

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/alu_dekoder.sv
// Combinational ALU operation decoder: maps the FSM's ALU usage class and the
// R-type function field onto the ALU result-mux select.
module alu_dekoder
  import ctrl_pkg::*;
(
  input  alu_class_e i_klasa,
  input  logic [1:0] i_funct,
  output logic [1:0] o_alu_sel
);

  always_comb begin
    o_alu_sel = ALU_AND;
    unique case (i_klasa)
      AC_INC,
      AC_ADD:   o_alu_sel = ALU_ADD;
      AC_FUNCT: o_alu_sel = i_funct;
      AC_SUB:   o_alu_sel = ALU_SUB;
      default:  o_alu_sel = ALU_AND;
    endcase
  end

endmodule

// File: rtl/njesia_kontrollit.sv
// Multicycle processor control unit: registered state, combinational
// Moore/Mealy datapath controls, halt trap and illegal-opcode pulse.
module njesia_kontrollit
  import ctrl_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [3:0] Opcode,
  input  logic [1:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [1:0] AluSel,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       Halted,
  output logic       IllegalOp,
  output logic [2:0] Gjendja
);

  state_e     r_state;
  alu_class_e w_klasa;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= ST_START;
    end else begin
      unique case (r_state)
        ST_START:  r_state <= ST_FETCH;
        ST_FETCH:  if (MemReady) r_state <= ST_DECODE;
        ST_DECODE: begin
          if (Opcode == OP_HALT)     r_state <= ST_HALT;
          else if (is_legal(Opcode)) r_state <= ST_EXEC;
          else                       r_state <= ST_FETCH;
        end
        ST_EXEC: begin
          if ((Opcode == OP_R) || (Opcode == OP_ADDI))    r_state <= ST_WB;
          else if ((Opcode == OP_LW) || (Opcode == OP_SW)) r_state <= ST_MEM;
          else                                             r_state <= ST_FETCH;
        end
        ST_MEM: begin
          if (MemReady) r_state <= (Opcode == OP_LW) ? ST_WB : ST_FETCH;
        end
        ST_WB:   r_state <= ST_FETCH;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_START;
      endcase
    end
  end

  // Opcode is stable from IRWrite onwards, so EXEC/MEM/WB decode it directly.
  always_comb begin
    w_klasa   = AC_NONE;
    AluSrcA   = 1'b0;
    AluSrcB   = SRCB_REGB;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    MemToReg  = 1'b0;
    Halted    = 1'b0;
    IllegalOp = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          AluSrcB = SRCB_ONE;
          w_klasa = AC_INC;
        end
      end
      ST_DECODE: begin
        IllegalOp = !is_legal(Opcode) && (Opcode != OP_HALT);
      end
      ST_EXEC: begin
        case (Opcode)
          OP_R: begin
            AluSrcA = 1'b1;
            AluSrcB = SRCB_REGB;
            w_klasa = AC_FUNCT;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            AluSrcA = 1'b1;
            AluSrcB = SRCB_IMM;
            w_klasa = AC_ADD;
          end
          OP_BEQ: begin
            AluSrcA = 1'b1;
            AluSrcB = SRCB_REGB;
            w_klasa = AC_SUB;
            PCSrc   = 1'b1;
            PCWrite = Zero;
          end
          default: w_klasa = AC_NONE;
        endcase
      end
      ST_MEM: begin
        IorD     = 1'b1;
        MemRead  = (Opcode == OP_LW);
        MemWrite = (Opcode == OP_SW);
      end
      ST_WB: begin
        RegWrite = 1'b1;
        RegDst   = (Opcode == OP_R);
        MemToReg = (Opcode == OP_LW);
      end
      ST_HALT: Halted = 1'b1;
      default: w_klasa = AC_NONE;
    endcase
  end

  alu_dekoder u_alu_dekoder (
    .i_klasa   (w_klasa),
    .i_funct   (Funct),
    .o_alu_sel (AluSel)
  );

  assign Gjendja = r_state;

endmodule

// File: tb/tb_njesia_kontrollit.sv
// Self-checking bench: instruction-level trace model builds the expected
// per-cycle control word; randomized wait states and don't-care inputs.
module tb_njesia_kontrollit;

  logic       Clock;
  logic       Resetn;
  logic [3:0] Opcode;
  logic [1:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic [1:0] AluSel;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc;
  logic       RegWrite, RegDst, MemToReg, Halted, IllegalOp;
  logic [2:0] Gjendja;

  int   total = 0;
  int   bad = 0;
  logic holdReady = 1'b0;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] sel;
    logic       sa;
    logic [1:0] sb;
    logic       iord, mrd, mwr, irw, pcw, pcs, rw, rd, m2r, h, ill;
  } exp_t;

  njesia_kontrollit dut (
    .Clock(Clock), .Resetn(Resetn), .Opcode(Opcode), .Funct(Funct),
    .Zero(Zero), .MemReady(MemReady), .AluSel(AluSel), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .Halted(Halted),
    .IllegalOp(IllegalOp), .Gjendja(Gjendja)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic rb();
    return ($urandom_range(0, 1) == 1);
  endfunction

  // Input that the current cycle ignores: random unless a test pins it high.
  function automatic logic dc();
    return holdReady ? 1'b1 : rb();
  endfunction

  function automatic logic isLegalOp(input logic [3:0] op);
    return (op == 4'b0000) || (op == 4'b0100) || (op == 4'b1000) ||
           (op == 4'b1100) || (op == 4'b0010);
  endfunction

  task automatic checkOutput(input exp_t e, input string tag);
    exp_t o;
    o = {Gjendja, AluSel, AluSrcA, AluSrcB, IorD, MemRead, MemWrite, IRWrite,
         PCWrite, PCSrc, RegWrite, RegDst, MemToReg, Halted, IllegalOp};
    total++;
    assert (o === e)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%05h expected=%05h", tag, o, e);
    end
  endtask

  // Called just after a falling edge; leaves just after the next falling edge.
  task automatic applyStimulus(input logic mr, input logic z, input exp_t e,
                               input string tag);
    MemReady = mr;
    Zero     = z;
    #1;
    checkOutput(e, tag);
    @(negedge Clock);
  endtask

  task automatic releaseReset();
    exp_t e;
    e = '0;
    Resetn = 1'b1;
    applyStimulus(dc(), rb(), e, "start");
  endtask

  task automatic doReset();
    exp_t e;
    e = '0;
    Resetn = 1'b0;
    applyStimulus(rb(), rb(), e, "reset_hold");
    releaseReset();
  endtask

  task automatic runInstr(input logic [3:0] op, input logic [1:0] fn,
                          input logic z, input int fWait, input int mWait,
                          input int abortAt, output logic aborted);
    exp_t e;
    aborted = 1'b0;
    Opcode  = op;
    Funct   = fn;
    for (int i = 0; i < fWait; i++) begin
      e = '0; e.st = 3'd1; e.mrd = 1'b1;
      applyStimulus(1'b0, rb(), e, "fetch_wait");
    end
    e = '0; e.st = 3'd1; e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    e.sb = 2'b01; e.sel = 2'b10;
    applyStimulus(1'b1, rb(), e, "fetch");
    e = '0; e.st = 3'd2;
    e.ill = !isLegalOp(op) && (op != 4'b1111);
    applyStimulus(dc(), rb(), e, "decode");
    if (!isLegalOp(op)) return;
    e = '0; e.st = 3'd3; e.sa = 1'b1;
    case (op)
      4'b0000: begin e.sb = 2'b00; e.sel = fn; end
      4'b0010: begin e.sb = 2'b00; e.sel = 2'b11; e.pcs = 1'b1; e.pcw = z; end
      default: begin e.sb = 2'b10; e.sel = 2'b10; end
    endcase
    applyStimulus(dc(), (op == 4'b0010) ? z : rb(), e, "exec");
    if (op == 4'b0010) return;
    if ((op == 4'b1000) || (op == 4'b1100)) begin
      e = '0; e.st = 3'd4; e.iord = 1'b1;
      e.mrd = (op == 4'b1000); e.mwr = (op == 4'b1100);
      for (int i = 0; i < mWait; i++) begin
        if (i == abortAt) begin
          MemReady = 1'b0;
          Zero     = rb();
          #1;
          checkOutput(e, "mem_before_reset");
          Resetn = 1'b0;
          #1;
          e = '0;
          checkOutput(e, "reset_mid_mem");
          @(negedge Clock);
          aborted = 1'b1;
          return;
        end
        applyStimulus(1'b0, rb(), e, "mem_wait");
      end
      applyStimulus(1'b1, rb(), e, "mem_done");
      if (op == 4'b1100) return;
    end
    e = '0; e.st = 3'd5; e.rw = 1'b1;
    e.rd = (op == 4'b0000); e.m2r = (op == 4'b1000);
    applyStimulus(dc(), rb(), e, "wb");
  endtask

  initial begin
    exp_t e;
    logic ab;
    logic [3:0] op;
    Opcode = 4'b0000; Funct = 2'b00; Zero = 1'b0; MemReady = 1'b0;
    Resetn = 1'b1;
    #2 Resetn = 1'b0;
    #1;
    e = '0;
    checkOutput(e, "reset_async");
    @(negedge Clock);
    applyStimulus(rb(), rb(), e, "reset_hold");

    holdReady = 1'b1;
    releaseReset();
    runInstr(4'b0000, 2'b01, 1'b0, 0, 0, -1, ab);
    holdReady = 1'b0;

    doReset();
    runInstr(4'b1000, 2'($urandom_range(0, 3)), 1'b0, 0, 3, -1, ab);
    runInstr(4'b0010, 2'b00, 1'b1, 0, 0, -1, ab);
    runInstr(4'b0010, 2'b00, 1'b0, 1, 0, -1, ab);
    runInstr(4'b0111, 2'b00, 1'b0, 0, 0, -1, ab);
    runInstr(4'b1100, 2'b10, 1'b0, 2, 1, -1, ab);
    runInstr(4'b0100, 2'b11, 1'b1, 0, 0, -1, ab);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: op = 4'b0000;
        1: op = 4'b0100;
        2: op = 4'b1000;
        3: op = 4'b1100;
        4: op = 4'b0010;
        default: begin
          op = 4'($urandom_range(0, 15));
          while (isLegalOp(op) || (op == 4'b1111)) op = 4'($urandom_range(0, 15));
        end
      endcase
      runInstr(op, 2'($urandom_range(0, 3)), rb(), $urandom_range(0, 3),
               $urandom_range(0, 4), -1, ab);
    end

    runInstr(4'b1100, 2'b00, 1'b0, 0, 4, 2, ab);
    e = '0;
    applyStimulus(rb(), rb(), e, "reset_hold");
    releaseReset();
    runInstr(4'b0100, 2'b00, 1'b0, 0, 0, -1, ab);

    runInstr(4'b1111, 2'b00, 1'b0, 0, 0, -1, ab);
    for (int n = 0; n < 20; n++) begin
      Opcode = 4'($urandom_range(0, 15));
      Funct  = 2'($urandom_range(0, 3));
      e = '0; e.st = 3'd6; e.h = 1'b1;
      applyStimulus(rb(), rb(), e, "halt");
    end
    doReset();
    runInstr(4'b0000, 2'b11, 1'b0, 0, 0, -1, ab);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
